// File: rtl/node_fifo_bank_pkg.sv
// rtl/node_fifo_bank_pkg.sv - shared sizing helpers and defaults for the ROM fetch / node FIFO path
package node_fifo_bank_pkg;

   localparam int DEF_NUM_NODES  = 4;
   localparam int DEF_DATA_WIDTH = 16;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // Node i owns bits [slice_lo(i, w) +: w] of any packed per-node data bus.
   function automatic int slice_lo(input int node, input int width);
      return node * width;
   endfunction

endpackage

// File: rtl/node_fifo.sv
// rtl/node_fifo.sv - single show-ahead FIFO feeding one neuron node
module node_fifo
   import node_fifo_bank_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   input  logic                        pop,
   output logic [DATA_WIDTH-1:0]       head,
   output logic [clog2(DEPTH):0]       cnt,
   output logic                        drop
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         cnt_q;
   logic                  is_full;
   logic                  is_empty;
   logic                  wr_ok;
   logic                  pop_ok;

   assign is_full  = (cnt_q == CW'(DEPTH));
   assign is_empty = (cnt_q == '0);
   assign wr_ok    = wr && !is_full;
   assign pop_ok   = pop && !is_empty;
   assign drop     = wr && is_full;
   assign cnt      = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage carries no reset; the head is masked while empty instead.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= wr_data;
   end

   assign head = is_empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/node_fifo_bank.sv
// rtl/node_fifo_bank.sv - per-node FIFO bank between the ROM fetch arbiter and the neuron nodes
module node_fifo_bank
   import node_fifo_bank_pkg::*;
#(
   parameter int NUM_NODES  = DEF_NUM_NODES,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = 4,
   parameter int WR_DLY     = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_NODES-1:0]            wr_en,
   input  logic [DATA_WIDTH-1:0]           wr_data,
   input  logic                            all_done,
   output logic                            full,
   output logic [NUM_NODES-1:0]            rd_valid,
   output logic [NUM_NODES*DATA_WIDTH-1:0] rd_data,
   input  logic [NUM_NODES-1:0]            rd_ready,
   output logic                            drained,
   output logic                            overflow
);

   localparam int CW = clog2(DEPTH) + 1;

   logic [NUM_NODES-1:0] pend;
   logic [NUM_NODES-1:0] pend_term;
   logic [NUM_NODES-1:0] pop;
   logic [NUM_NODES-1:0] drop;
   logic [NUM_NODES-1:0] near_full;
   logic [CW-1:0]        cnt [NUM_NODES];
   logic                 all_done_seen;
   logic                 drained_q;
   logic                 overflow_q;
   logic                 drain_cond;

   // Align the arbiter's select with the ROM's registered read data.
   generate
      if (WR_DLY == 1) begin : g_dly
         logic [NUM_NODES-1:0] pend_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               pend_q <= '0;
            else
               pend_q <= wr_en;
         end
         assign pend      = pend_q;
         assign pend_term = pend_q;
      end else begin : g_nodly
         assign pend      = wr_en;
         assign pend_term = '0;
      end
   endgenerate

   assign pop = rd_ready & rd_valid;

   generate
      for (genvar i = 0; i < NUM_NODES; i++) begin : g_node
         logic [DATA_WIDTH-1:0] head;
         logic [CW:0]           occ;

         node_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
         ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr      (pend[i]),
            .wr_data (wr_data),
            .pop     (pop[i]),
            .head    (head),
            .cnt     (cnt[i]),
            .drop    (drop[i])
         );

         // Occupancy including the write in flight and the one being issued now.
         assign occ          = {1'b0, cnt[i]} + (CW + 1)'(pend_term[i]) + (CW + 1)'(wr_en[i]);
         assign near_full[i] = (occ >= (CW + 1)'(DEPTH));
         assign rd_valid[i]  = (cnt[i] != '0);
         assign rd_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = head;
      end
   endgenerate

   assign full       = |near_full;
   assign drain_cond = all_done_seen && (pend == '0) && (wr_en == '0) && (rd_valid == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         all_done_seen <= 1'b0;
         drained_q     <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         if (all_done)
            all_done_seen <= 1'b1;
         if (drain_cond)
            drained_q <= 1'b1;
         if (|drop)
            overflow_q <= 1'b1;
      end
   end

   assign drained  = drained_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_node_fifo_bank.sv
// tb/tb_node_fifo_bank.sv - self-checking bench for node_fifo_bank against a queue model
module tb_node_fifo_bank;

   localparam int NN    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [NN-1:0]       wr_en = '0;
   logic [DW-1:0]       wr_data = '0;
   logic                all_done = 1'b0;
   logic                full;
   logic [NN-1:0]       rd_valid;
   logic [NN*DW-1:0]    rd_data;
   logic [NN-1:0]       rd_ready = '0;
   logic                drained;
   logic                overflow;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] q [NN][$];
   logic [NN-1:0] pend_m = '0;
   bit            ovf_m = 0;
   bit            done_m = 0;
   bit            drained_m = 0;

   node_fifo_bank #(
      .NUM_NODES  (NN),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .WR_DLY     (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .all_done (all_done),
      .full     (full),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_ready (rd_ready),
      .drained  (drained),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_full(input logic [NN-1:0] we);
      bit f;
      f = 0;
      for (int i = 0; i < NN; i++)
         if (q[i].size() + int'(pend_m[i]) + int'(we[i]) >= DEPTH)
            f = 1;
      return f;
   endfunction

   task automatic check_outputs();
      logic [NN-1:0]    ev;
      logic [NN*DW-1:0] ed;
      ev = '0;
      ed = '0;
      for (int i = 0; i < NN; i++) begin
         if (q[i].size() > 0) begin
            ev[i] = 1'b1;
            ed[i*DW +: DW] = q[i][0];
         end
      end
      check("rd_valid", 64'(rd_valid), 64'(ev));
      check("rd_data",  64'(rd_data),  64'(ed));
      check("full",     64'(full),     64'(model_full(wr_en)));
      check("drained",  64'(drained),  64'(drained_m));
      check("overflow", 64'(overflow), 64'(ovf_m));
   endtask

   // One clock: drive, check the pre-edge view, then advance the model by the edge.
   task automatic step(input logic [NN-1:0] we, input logic [DW-1:0] wd,
                       input logic [NN-1:0] rr, input bit ad);
      bit all_empty;
      int sz;
      @(negedge clk);
      wr_en    = we;
      wr_data  = wd;
      rd_ready = rr;
      all_done = ad;
      assert ($onehot0(we));
      #1;
      check_outputs();
      @(posedge clk);
      all_empty = 1;
      for (int i = 0; i < NN; i++)
         if (q[i].size() != 0) all_empty = 0;
      if (done_m && pend_m == '0 && we == '0 && all_empty)
         drained_m = 1;
      for (int i = 0; i < NN; i++) begin
         sz = q[i].size();
         if (rr[i] && sz > 0)
            void'(q[i].pop_front());
         if (pend_m[i]) begin
            if (sz == DEPTH) ovf_m = 1;
            else q[i].push_back(wd);
         end
      end
      if (ad) done_m = 1;
      pend_m = we;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      wr_en    = '0;
      wr_data  = 16'hDEAD;
      rd_ready = '0;
      all_done = 1'b0;
      #1;
      check("rst_valid",    64'(rd_valid), 64'(0));
      check("rst_full",     64'(full),     64'(0));
      check("rst_overflow", 64'(overflow), 64'(0));
      check("rst_drained",  64'(drained),  64'(0));
      check("rst_data",     64'(rd_data),  64'(0));
      for (int i = 0; i < NN; i++) q[i].delete();
      pend_m = '0; ovf_m = 0; done_m = 0; drained_m = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [NN-1:0] we;
      logic [NN-1:0] rr;
      bit            legal;

      do_reset();

      // Broadcast data lands one node per cycle.
      step(4'b0001, 16'h0000, 4'b0, 0);
      step(4'b0010, 16'h0011, 4'b0, 0);
      step(4'b0100, 16'h0022, 4'b0, 0);
      step(4'b1000, 16'h0033, 4'b0, 0);
      step(4'b0000, 16'h0044, 4'b0, 0);
      #2;
      check("t1_valid", 64'(rd_valid), 64'h000f);
      check("t1_data",  64'(rd_data),  64'h0044_0033_0022_0011);

      // Fill node 0, then an illegal fifth write is dropped.
      do_reset();
      step(4'b0001, 16'h0000, 4'b0, 0);
      step(4'b0001, 16'hA001, 4'b0, 0);
      step(4'b0001, 16'hA002, 4'b0, 0);
      step(4'b0001, 16'hA003, 4'b0, 0);
      step(4'b0001, 16'hA004, 4'b0, 0);
      step(4'b0000, 16'hA005, 4'b0, 0);
      #2;
      check("t2_overflow", 64'(overflow), 64'h1);
      check("t2_head",     64'(rd_data[15:0]), 64'hA001);
      check("t2_full",     64'(full), 64'h1);

      // Pop one, refill into the wrapped slot, drain in order.
      step(4'b0000, 16'h0, 4'b0001, 0);
      step(4'b0000, 16'h0, 4'b0000, 0);
      step(4'b0001, 16'h0, 4'b0000, 0);
      step(4'b0000, 16'hA006, 4'b0000, 0);
      for (int k = 0; k < 5; k++)
         step(4'b0000, 16'h0, 4'b0001, 0);

      // Write and pop together on node 2 holding two words.
      do_reset();
      step(4'b0100, 16'h0000, 4'b0, 0);
      step(4'b0100, 16'hB001, 4'b0, 0);
      step(4'b0000, 16'hB002, 4'b0, 0);
      step(4'b0100, 16'h0000, 4'b0, 0);
      step(4'b0000, 16'hB003, 4'b0100, 0);
      #2;
      check("t4_head", 64'(rd_data[47:32]), 64'hB002);
      step(4'b0000, 16'h0, 4'b0000, 0);

      // Drain with all_done raised alongside the final write.
      step(4'b0001, 16'h0000, 4'b0000, 1);
      step(4'b0000, 16'hC001, 4'b0000, 0);
      step(4'b0000, 16'h0000, 4'b0000, 0);
      for (int k = 0; k < 6; k++)
         step(4'b0000, 16'h0, 4'b1111, 0);
      #2;
      check("t5_drained", 64'(drained), 64'h1);

      // Random traffic from an arbiter that respects the aggregate full flag.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         legal = 1;
         for (int i = 0; i < NN; i++)
            if (q[i].size() + int'(pend_m[i]) >= DEPTH) legal = 0;
         we = '0;
         if (legal && ($urandom_range(0, 3) != 0))
            we[$urandom_range(0, NN - 1)] = 1'b1;
         rr = NN'($urandom);
         step(we, DW'($urandom), rr, 0);
      end
      step(4'b0000, DW'($urandom), 4'b0, 1);
      for (int k = 0; k < 12; k++)
         step(4'b0000, 16'h0, 4'b1111, 0);
      #2;
      check("rand_drained",  64'(drained),  64'h1);
      check("rand_overflow", 64'(overflow), 64'h0);

      // Reset mid-stream with a delayed write still pending.
      do_reset();
      for (int k = 0; k < 6; k++)
         step(NN'(1 << (k % NN)), DW'($urandom), 4'b0, 0);
      do_reset();
      step(4'b0000, 16'hBEEF, 4'b0, 0);
      step(4'b0000, 16'h0000, 4'b0, 0);
      #2;
      check("t6_valid", 64'(rd_valid), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
